// File: rtl/dds_param_scheduler_pkg.sv
// rtl/dds_param_scheduler_pkg.sv - shared widths, command record and due/late helpers
package dds_param_scheduler_pkg;

  localparam int TS_W    = 48;
  localparam int FREQ_W  = 48;
  localparam int PHASE_W = 14;

  // "time" is a reserved word, so the timestamp field is cmd_time.
  typedef struct packed {
    logic [TS_W-1:0]    cmd_time;
    logic [FREQ_W-1:0]  freq;
    logic [PHASE_W-1:0] phase;
    logic               rst_phase;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  function automatic logic is_due(input logic [TS_W-1:0] t_cmd, input logic [TS_W-1:0] t_now);
    return (t_cmd <= t_now);
  endfunction

  function automatic logic is_late(input logic [TS_W-1:0] t_cmd, input logic [TS_W-1:0] t_now);
    return (t_cmd < t_now);
  endfunction

endpackage

// File: rtl/dds_cmd_fifo.sv
// rtl/dds_cmd_fifo.sv - in-order command queue with registered occupancy and flags
module dds_cmd_fifo
  import dds_param_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_push,
  input  logic [CMD_W-1:0] i_data,
  input  logic             i_pop,
  output logic [CMD_W-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dds_param_scheduler.sv
// rtl/dds_param_scheduler.sv - timestamp counter and timed application of queued DDS parameters
module dds_param_scheduler
  import dds_param_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [TS_W-1:0]    s_time,
  input  logic [FREQ_W-1:0]  s_freq,
  input  logic [PHASE_W-1:0] s_phase,
  input  logic               s_rst_phase,
  input  logic               sync_clear,
  input  logic               err_clear,
  output logic [TS_W-1:0]    timeoffset,
  output logic [FREQ_W-1:0]  freq,
  output logic [PHASE_W-1:0] phase,
  output logic [TS_W-1:0]    timestamp,
  output logic               applied,
  output logic               late_err
);

  logic               r_ready_en;
  logic [TS_W-1:0]    r_ts;
  logic [TS_W-1:0]    r_timeoffset;
  logic [FREQ_W-1:0]  r_freq;
  logic [PHASE_W-1:0] r_phase;
  logic               r_applied;
  logic               r_late_err;

  cmd_t               w_in_cmd;
  cmd_t               w_head;
  logic [CMD_W-1:0]   w_head_bits;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_apply;
  logic               w_late;

  assign w_in_cmd = '{cmd_time: s_time, freq: s_freq, phase: s_phase, rst_phase: s_rst_phase};
  assign w_head   = cmd_t'(w_head_bits);

  // s_ready depends only on registered state, never on the apply decision.
  assign s_ready = r_ready_en & ~w_full;
  assign w_push  = s_valid & s_ready;

  assign w_apply = ~w_empty & is_due(w_head.cmd_time, r_ts);
  assign w_late  = is_late(w_head.cmd_time, r_ts);

  dds_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_data  (w_in_cmd),
    .i_pop   (w_apply),
    .o_data  (w_head_bits),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ready_en <= 1'b0;
      r_ts       <= '0;
    end else begin
      r_ready_en <= 1'b1;
      if (sync_clear) begin
        r_ts <= '0;
      end else begin
        r_ts <= r_ts + TS_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_timeoffset <= '0;
      r_freq       <= '0;
      r_phase      <= '0;
      r_applied    <= 1'b0;
    end else begin
      r_applied <= w_apply;
      if (w_apply) begin
        r_freq  <= w_head.freq;
        r_phase <= w_head.phase;
        if (w_head.rst_phase) begin
          r_timeoffset <= w_head.cmd_time;
        end
      end
    end
  end

  // A late apply outranks a simultaneous clear so the event is never lost.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_late_err <= 1'b0;
    end else if (w_apply && w_late) begin
      r_late_err <= 1'b1;
    end else if (err_clear) begin
      r_late_err <= 1'b0;
    end
  end

  assign timeoffset = r_timeoffset;
  assign freq       = r_freq;
  assign phase      = r_phase;
  assign timestamp  = r_ts;
  assign applied    = r_applied;
  assign late_err   = r_late_err;

endmodule

// File: tb/tb_dds_param_scheduler.sv
// tb/tb_dds_param_scheduler.sv - directed self-checking bench for dds_param_scheduler
module tb_dds_param_scheduler;

  logic        clk = 1'b0;
  logic        resetn;
  logic        s_valid;
  logic        s_ready;
  logic [47:0] s_time;
  logic [47:0] s_freq;
  logic [13:0] s_phase;
  logic        s_rst_phase;
  logic        sync_clear;
  logic        err_clear;
  logic [47:0] timeoffset;
  logic [47:0] freq;
  logic [13:0] phase;
  logic [47:0] timestamp;
  logic        applied;
  logic        late_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dds_param_scheduler #(.DEPTH(4)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_time      (s_time),
    .s_freq      (s_freq),
    .s_phase     (s_phase),
    .s_rst_phase (s_rst_phase),
    .sync_clear  (sync_clear),
    .err_clear   (err_clear),
    .timeoffset  (timeoffset),
    .freq        (freq),
    .phase       (phase),
    .timestamp   (timestamp),
    .applied     (applied),
    .late_err    (late_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic push(input logic [47:0] t, input logic [47:0] f, input logic [13:0] p,
                      input logic r, output logic acc, output logic [47:0] ts_at);
    s_valid     = 1'b1;
    s_time      = t;
    s_freq      = f;
    s_phase     = p;
    s_rst_phase = r;
    acc         = s_ready;
    ts_at       = timestamp;
    @(negedge clk);
    s_valid     = 1'b0;
  endtask

  task automatic wait_ts(input logic [47:0] target);
    int n = 0;
    while (timestamp != target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("wait_ts", timestamp, target);
  endtask

  task automatic wait_applied(input int limit, output logic [47:0] ts_seen);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!applied && n < limit);
    check("applied_seen", applied, 1'b1);
    ts_seen = timestamp;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic [47:0] tp;
    logic [47:0] tsa;
    int          n_acc;
    int          n;

    resetn = 1'b0; s_valid = 1'b0; s_time = '0; s_freq = '0; s_phase = '0;
    s_rst_phase = 1'b0; sync_clear = 1'b0; err_clear = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_ts", timestamp, 0);
    check("rst_freq", freq, 0);
    check("rst_phase", phase, 0);
    check("rst_toff", timeoffset, 0);
    check("rst_applied", applied, 0);
    check("rst_late", late_err, 0);
    resetn = 1'b1;
    @(negedge clk);
    check("ready_after_rst", s_ready, 1);
    check("ts_after_rst", timestamp, 1);

    // Exact-time apply with phase reload.
    wait_ts(10);
    push(100, 48'h1000, 14'h3FFF, 1'b1, acc, tp);
    check("t1_acc", acc, 1);
    wait_applied(200, tsa);
    check("t1_apply_ts", tsa, 101);
    check("t1_toff", timeoffset, 100);
    check("t1_freq", freq, 48'h1000);
    check("t1_phase", phase, 14'h3FFF);
    check("t1_late", late_err, 0);
    @(negedge clk);
    check("t1_single_pulse", applied, 0);

    // sync_clear with a queued command.
    wait_ts(48'h120);
    push(48'h200, 48'h5555, 14'h0555, 1'b1, acc, tp);
    wait_ts(48'h123);
    sync_clear = 1'b1;
    @(negedge clk);
    sync_clear = 1'b0;
    check("sync_ts_zero", timestamp, 0);
    check("sync_no_apply", applied, 0);
    check("sync_freq_hold", freq, 48'h1000);
    check("sync_toff_hold", timeoffset, 100);
    wait_applied(1000, tsa);
    check("sync_apply_ts", tsa, 48'h201);
    check("sync_freq", freq, 48'h5555);
    check("sync_phase", phase, 14'h0555);
    check("sync_toff", timeoffset, 48'h200);

    // Late command, then err_clear.
    push(5, 48'h2222, 14'h0022, 1'b0, acc, tp);
    wait_applied(4, tsa);
    check("late_latency", tsa, tp + 2);
    check("late_set", late_err, 1);
    check("late_freq", freq, 48'h2222);
    check("late_toff_hold", timeoffset, 48'h200);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    check("late_cleared", late_err, 0);

    // Late apply coinciding with err_clear keeps the flag set.
    push(6, 48'h3333, 14'h0033, 1'b0, acc, tp);
    err_clear = 1'b1;
    wait_applied(4, tsa);
    err_clear = 1'b0;
    check("late_wins", late_err, 1);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    check("late_cleared2", late_err, 0);

    // Fill the queue: fifth push must be refused.
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      push(1000, 48'(i + 1), 14'(i), 1'b0, acc, tp);
      if (acc) n_acc++;
      if (i == 4) check("fill_5th_refused", acc, 0);
    end
    check("fill_accepted", n_acc, 4);
    check("fill_not_ready", s_ready, 0);
    wait_applied(1000, tsa);
    check("fill_first_ts", tsa, 1001);
    check("fill_first_freq", freq, 1);
    check("fill_exact_not_late", late_err, 0);
    check("fill_toff_hold", timeoffset, 48'h200);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      check("fill_b2b_applied", applied, 1);
      check("fill_b2b_freq", freq, 64'(k));
      check("fill_b2b_phase", phase, 64'(k - 1));
    end
    check("fill_b2b_late", late_err, 1);
    @(negedge clk);
    check("fill_done", applied, 0);
    check("fill_ready_again", s_ready, 1);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;

    // rst_phase=1 then rst_phase=0 at the same time.
    push(1020, 48'hAAAA, 14'h00AA, 1'b1, acc, tp);
    push(1020, 48'hBBBB, 14'h00BB, 1'b0, acc, tp);
    wait_applied(100, tsa);
    check("pair_ts", tsa, 1021);
    check("pair_toff_a", timeoffset, 1020);
    check("pair_freq_a", freq, 48'hAAAA);
    @(negedge clk);
    check("pair_applied_b", applied, 1);
    check("pair_toff_b", timeoffset, 1020);
    check("pair_freq_b", freq, 48'hBBBB);
    check("pair_phase_b", phase, 14'h00BB);

    // Counter wrap.
    @(negedge clk);
    force dut.r_ts = 48'hFFFF_FFFF_FFFD;
    @(negedge clk);
    release dut.r_ts;
    n = 0;
    while (timestamp != 48'hFFFF_FFFF_FFFF && n < 6) begin
      @(negedge clk);
      n++;
    end
    check("wrap_max_seen", timestamp, 48'hFFFF_FFFF_FFFF);
    @(negedge clk);
    check("wrap_zero", timestamp, 0);

    // Reset with queued commands.
    for (int i = 0; i < 3; i++) begin
      push(48'hFFFF_FFFF_FF00, 48'h9999, 14'h0099, 1'b1, acc, tp);
      check("rq_acc", acc, 1);
    end
    resetn = 1'b0;
    @(negedge clk);
    check("rq_applied", applied, 0);
    check("rq_ready", s_ready, 0);
    check("rq_freq", freq, 0);
    check("rq_phase", phase, 0);
    check("rq_toff", timeoffset, 0);
    check("rq_ts", timestamp, 0);
    check("rq_late", late_err, 0);
    resetn = 1'b1;
    @(negedge clk);
    check("rq_ready_back", s_ready, 1);
    check("rq_no_apply", applied, 0);
    push(0, 48'h7777, 14'h0077, 1'b0, acc, tp);
    wait_applied(4, tsa);
    check("rq_fifo_flushed", tsa, tp + 2);
    check("rq_new_freq", freq, 48'h7777);
    check("rq_toff_zero", timeoffset, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
